puzzle_loader: RTL and testbench

Write-side front end for the 64-entry x 5-bit puzzle register file.
- Accepts a 3x3 start board as a stream of 9 tiles over a valid/ready handshake.
- Validates the board: range, permutation and solvability.
- Issues the register-file writes that initialise the board cells, path area, comp flag, counter, limit and hole entries before the solver starts.
- Drives the register file's we/dst/data write port. Only one write is issued per cycle.

---
 rtl/puzzle_loader.sv | 255 +++++++++++++++++++++++++
 tb/tb_puzzle_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puzzle_loader.sv
// puzzle_loader
//
// Write-side front end for the 64 x 5-bit puzzle register file. A 3x3 start
// board arrives as nine tiles over a valid/ready stream. Each tile is written
// straight into its cell entry while the board is checked for out-of-range
// values, duplicates and solvability (inversion parity). A good board is then
// followed by the initialisation writes the solver expects: the path/comp
// area cleared, then the move counter, depth limit and blank position.
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset; aborts any load in progress
//   start     one-cycle pulse that begins a load (ignored while busy or done)
//   limit     search-depth limit, captured with start
//   in_valid  tile valid
//   in_data   tile value, 0 = blank, 1..8 = tile, row-major, cell 0 first
//   in_ready  tile accept, high only while tiles are being collected
//   we        register-file write enable (registered)
//   dst       register-file write address (registered)
//   data      register-file write data (registered)
//   busy      load in progress
//   done      one-cycle completion pulse
//   err       0 ok, 1 out of range, 2 duplicate, 3 unsolvable; held until next start

module puzzle_loader #(
    parameter int CELLS      = 9,
    parameter int CNT_ADDR   = 27,
    parameter int LIMIT_ADDR = 28,
    parameter int HOLE_ADDR  = 29,
    parameter int CLR_FIRST  = 30,
    parameter int CLR_LAST   = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] limit,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic       we,
    output logic [5:0] dst,
    output logic [4:0] data,
    output logic       busy,
    output logic       done,
    output logic [1:0] err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_CLEAR,
        S_FINAL
    } state_t;

    localparam logic [3:0] LAST_IDX   = 4'(CELLS - 1);
    localparam logic [3:0] MAX_TILE   = 4'(CELLS - 1);
    localparam logic [5:0] CNT_DST    = 6'(CNT_ADDR);
    localparam logic [5:0] LIMIT_DST  = 6'(LIMIT_ADDR);
    localparam logic [5:0] HOLE_DST   = 6'(HOLE_ADDR);
    localparam logic [5:0] CLR_START  = 6'(CLR_FIRST);
    localparam logic [5:0] CLR_END    = 6'(CLR_LAST);

    localparam logic [1:0] ERR_OK     = 2'd0;
    localparam logic [1:0] ERR_RANGE  = 2'd1;
    localparam logic [1:0] ERR_DUP    = 2'd2;
    localparam logic [1:0] ERR_PARITY = 2'd3;

    state_t             state;
    logic [3:0]         idx;
    logic [CELLS-1:0]   seen_mask;
    logic               inv_parity;
    logic               range_flag;
    logic               dup_flag;
    logic [3:0]         hole;
    logic [4:0]         limit_q;
    logic [5:0]         clr_addr;
    logic [1:0]         fin_step;

    logic               accept;
    logic               tile_in_range;
    logic               tile_seen;
    logic               gt_parity;
    logic [CELLS-1:0]   tile_onehot;

    // in_ready is only ever high in LOAD, so the handshake alone marks a tile.
    assign accept        = in_valid & in_ready;
    assign tile_in_range = (in_data <= MAX_TILE);

    // Per-tile lookups against the tiles already seen. gt_parity is the parity
    // of the number of earlier nonzero tiles larger than the current one, i.e.
    // the inversions this tile contributes. The blank (bit 0) never counts,
    // and the current tile is not yet in seen_mask so it excludes itself.
    // Out-of-range values match no bit, so they never touch the mask.
    always_comb begin
        tile_seen   = 1'b0;
        gt_parity   = 1'b0;
        tile_onehot = '0;
        for (int j = 0; j < CELLS; j++) begin
            if (4'(j) == in_data) begin
                tile_seen      = seen_mask[j];
                tile_onehot[j] = 1'b1;
            end
            if ((j >= 1) && (4'(j) > in_data)) begin
                gt_parity = gt_parity ^ seen_mask[j];
            end
        end
    end

    // Main controller. All outputs are registered here; we and done default
    // low each cycle so they only pulse in the cycles that set them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            seen_mask  <= '0;
            inv_parity <= 1'b0;
            range_flag <= 1'b0;
            dup_flag   <= 1'b0;
            hole       <= '0;
            limit_q    <= '0;
            clr_addr   <= '0;
            fin_step   <= '0;
            in_ready   <= 1'b0;
            we         <= 1'b0;
            dst        <= '0;
            data       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= ERR_OK;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;

            case (state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is treated as
                    // arriving while still busy and is dropped.
                    if (start && !done) begin
                        limit_q    <= limit;
                        idx        <= '0;
                        seen_mask  <= '0;
                        inv_parity <= 1'b0;
                        range_flag <= 1'b0;
                        dup_flag   <= 1'b0;
                        hole       <= '0;
                        err        <= ERR_OK;
                        busy       <= 1'b1;
                        in_ready   <= 1'b1;
                        state      <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (accept) begin
                        // Cell write goes out even for a bad tile; the solver
                        // never starts on a rejected board anyway.
                        we   <= 1'b1;
                        dst  <= {2'b00, idx};
                        data <= {1'b0, in_data};

                        if (!tile_in_range) begin
                            range_flag <= 1'b1;
                        end else if (tile_seen) begin
                            dup_flag <= 1'b1;
                        end else begin
                            seen_mask <= seen_mask | tile_onehot;
                        end

                        if (in_data == 4'd0) begin
                            hole <= idx;
                        end

                        if (tile_in_range && (in_data != 4'd0)) begin
                            inv_parity <= inv_parity ^ gt_parity;
                        end

                        idx <= idx + 4'd1;

                        if (idx == LAST_IDX) begin
                            in_ready <= 1'b0;
                            state    <= S_CHECK;
                        end
                    end
                end

                S_CHECK: begin
                    // An odd inversion count makes a 3x3 board unreachable
                    // from the goal, so it is rejected like the other errors.
                    if (range_flag || dup_flag || inv_parity) begin
                        if (range_flag) begin
                            err <= ERR_RANGE;
                        end else if (dup_flag) begin
                            err <= ERR_DUP;
                        end else begin
                            err <= ERR_PARITY;
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        clr_addr <= CLR_START;
                        state    <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    we   <= 1'b1;
                    dst  <= clr_addr;
                    data <= 5'd0;
                    if (clr_addr == CLR_END) begin
                        fin_step <= 2'd0;
                        state    <= S_FINAL;
                    end else begin
                        clr_addr <= clr_addr + 6'd1;
                    end
                end

                S_FINAL: begin
                    // Three scalar writes, then one extra step so done lands
                    // in the cycle after the last write is presented.
                    case (fin_step)
                        2'd0: begin
                            we   <= 1'b1;
                            dst  <= CNT_DST;
                            data <= 5'd0;
                        end
                        2'd1: begin
                            we   <= 1'b1;
                            dst  <= LIMIT_DST;
                            data <= limit_q;
                        end
                        2'd2: begin
                            we   <= 1'b1;
                            dst  <= HOLE_DST;
                            data <= {1'b0, hole};
                        end
                        default: begin
                            done  <= 1'b1;
                            err   <= ERR_OK;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    endcase
                    fin_step <= fin_step + 2'd1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puzzle_loader.sv
// tb_puzzle_loader
//
// Directed bench for puzzle_loader. The stimulus side pushes the expected
// register-file writes and completion records into queues as each board is
// issued; an independent monitor on the falling edge pops and compares them
// whenever the DUT presents a write or a done pulse.

module tb_puzzle_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] limit;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       we;
    logic [5:0] dst;
    logic [4:0] data;
    logic       busy;
    logic       done;
    logic [1:0] err;

    puzzle_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .limit    (limit),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we       (we),
        .dst      (dst),
        .data     (data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] dst;
        logic [4:0] data;
    } wr_t;

    typedef struct {
        logic [1:0] err;
        int         lat;
    } done_t;

    wr_t   wq[$];
    done_t dq[$];
    wr_t   exp_w;
    done_t exp_d;

    int checks = 0;
    int passes = 0;

    logic [3:0] board[9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        $display("[TB] FAIL %s: got timeout/unexpected event, expected none", name);
    endtask

    // Monitor: counts accepted tiles to time done against the last accept,
    // and checks every write and every done pulse against the queues.
    int ncyc     = 0;
    int acc_cnt  = 0;
    int last_acc = 0;

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            acc_cnt = 0;
        end else if (in_valid && in_ready) begin
            acc_cnt++;
            if (acc_cnt == 9) begin
                last_acc = ncyc;
                acc_cnt  = 0;
            end
        end

        if (we) begin
            if (wq.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_write: got dst=%0d data=%0d, expected no write",
                         dst, data);
            end else begin
                exp_w = wq.pop_front();
                check("write_dst", int'(dst), int'(exp_w.dst));
                check("write_data", int'(data), int'(exp_w.data));
            end
        end

        if (done) begin
            if (dq.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_done: got done=1 err=%0d, expected no done", err);
            end else begin
                exp_d = dq.pop_front();
                check("done_err", int'(err), int'(exp_d.err));
                check("done_latency", ncyc - 1 - last_acc, exp_d.lat);
                check("done_busy_low", int'(busy), 0);
            end
        end
    end

    // Offers one tile and waits (bounded) for it to be taken; with gap>0 the
    // valid line is then dropped for that many cycles while in_ready must stay up.
    task automatic send_tile(input logic [3:0] t, input int gap);
        bit got = 1'b0;
        in_valid = 1'b1;
        in_data  = t;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) begin
            note_fail("tile_accept_timeout");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("in_ready_gap", int'(in_ready), 1);
            @(posedge clk);
            #1;
        end
    endtask

    // Queues the expected writes and completion for the board in 'board',
    // pulses start and streams the first n tiles.
    task automatic apply_stimulus(input logic [4:0] lim, input logic [1:0] exp_err,
                                  input logic [3:0] exp_hole, input int gap, input int n);
        for (int i = 0; i < n; i++) begin
            wq.push_back({6'(i), {1'b0, board[i]}});
        end
        if (n == 9) begin
            if (exp_err == 2'd0) begin
                for (int a = 30; a <= 63; a++) begin
                    wq.push_back({6'(a), 5'd0});
                end
                wq.push_back({6'd27, 5'd0});
                wq.push_back({6'd28, lim});
                wq.push_back({6'd29, {1'b0, exp_hole}});
                dq.push_back('{exp_err, 39});
            end else begin
                dq.push_back('{exp_err, 1});
            end
        end
        start = 1'b1;
        limit = lim;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            send_tile(board[i], (i < n - 1) ? gap : 0);
        end
    endtask

    task automatic wait_done(input int max_cycles);
        bit seen = 1'b0;
        for (int c = 0; c < max_cycles && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) note_fail("done_timeout");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $display("[TB] %0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        limit    = 5'd0;
        in_valid = 1'b0;
        in_data  = 4'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_we", int'(we), 0);
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_dst", int'(dst), 0);
        check("reset_data", int'(data), 0);
        check("reset_err", int'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Solved board, back-to-back, with an ignored start during CLEAR
        // that also presents a different limit.
        $display("[TB] solved board, limit 20");
        board = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0};
        apply_stimulus(5'd20, 2'd0, 4'd8, 0, 9);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        limit = 5'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_during_clear", int'(busy), 1);
        wait_done(100);
        @(posedge clk);
        #1;

        $display("[TB] one inversion, unsolvable");
        board = '{4'd2, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0};
        apply_stimulus(5'd10, 2'd3, 4'd8, 0, 9);
        wait_done(20);
        @(posedge clk);
        #1;

        $display("[TB] out-of-range tile");
        board = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd6, 4'd7, 4'd8, 4'd0};
        apply_stimulus(5'd10, 2'd1, 4'd8, 0, 9);
        wait_done(20);
        @(posedge clk);
        #1;

        // Duplicate board; a start presented in the done cycle must be dropped.
        $display("[TB] duplicate tile, start during done");
        board = '{4'd1, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0};
        apply_stimulus(5'd10, 2'd2, 4'd8, 0, 9);
        wait_done(20);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("start_on_done_busy", int'(busy), 0);
        check("start_on_done_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;

        $display("[TB] blank first, valid every other cycle");
        board = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        apply_stimulus(5'd7, 2'd0, 4'd0, 1, 9);
        wait_done(100);
        @(posedge clk);
        #1;

        $display("[TB] reset after five tiles");
        board = '{4'd3, 4'd1, 4'd2, 4'd5, 4'd4, 4'd6, 4'd7, 4'd8, 4'd0};
        apply_stimulus(5'd12, 2'd0, 4'd8, 0, 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_we", int'(we), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_done", int'(done), 0);
        @(posedge clk);
        #1;

        $display("[TB] fresh board after abort");
        board = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd7, 4'd8};
        apply_stimulus(5'd31, 2'd0, 4'd6, 0, 9);
        wait_done(100);

        repeat (5) @(negedge clk);
        check("write_queue_empty", wq.size(), 0);
        check("done_queue_empty", dq.size(), 0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
